// File: rtl/dco_nbit_v2_if.sv
// SFR-side bus of the DCO: control/period/duty values in, hardware write-back strobes out.
interface dco_nbit_v2_if #(parameter int DATA_WIDTH = 32);
  logic [DATA_WIDTH-1:0] dco_ctrl;
  logic [DATA_WIDTH-1:0] dco_cnt;
  logic [DATA_WIDTH-1:0] dco_duty;
  logic [DATA_WIDTH-1:0] hw_up_dco_ctrl;
  logic [DATA_WIDTH-1:0] hw_val_dco_ctrl;
  logic [DATA_WIDTH-1:0] hw_up_dco_cnt;
  logic [DATA_WIDTH-1:0] hw_val_dco_cnt;
  logic [DATA_WIDTH-1:0] hw_up_dco_duty;
  logic [DATA_WIDTH-1:0] hw_val_dco_duty;

  modport master (
    output dco_ctrl, dco_cnt, dco_duty,
    input  hw_up_dco_ctrl, hw_val_dco_ctrl, hw_up_dco_cnt, hw_val_dco_cnt,
           hw_up_dco_duty, hw_val_dco_duty
  );

  modport slave (
    input  dco_ctrl, dco_cnt, dco_duty,
    output hw_up_dco_ctrl, hw_val_dco_ctrl, hw_up_dco_cnt, hw_val_dco_cnt,
           hw_up_dco_duty, hw_val_dco_duty
  );
endinterface

// File: rtl/dco_nbit_v2.sv
// Prescaled N-bit period/duty generator with shadowed reload, one-shot mode and
// BUSY/DONE/ON write-back into the control SFR.
module dco_nbit_v2 #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 20,
  parameter int PSC_W      = 4
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  input  logic           sys_clk_en,
  dco_nbit_v2_if.slave   bus,
  output logic           dco_clk_out
);
  localparam int PRE_W  = (1 << PSC_W) - 1;
  localparam int B_ON   = 0;
  localparam int B_BUSY = 8;
  localparam int B_DONE = 9;

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t state_q, state_d;

  logic             on, mode, pol;
  logic [PSC_W-1:0] psc;
  logic [N-1:0]     per_in, hi_in;

  logic [N-1:0]     cnt_q, per_q, hi_q;
  logic [PSC_W-1:0] psc_q;
  logic             mode_q;
  logic [PRE_W-1:0] pre_q, pre_mask;
  logic             tick, term, raw, out_q;
  logic             load, clr;

  logic [DATA_WIDTH-1:0] up_d, val_d, up_q, val_q;
  logic                  unused_bits;

  assign on     = bus.dco_ctrl[0];
  assign mode   = bus.dco_ctrl[1];
  assign pol    = bus.dco_ctrl[2];
  assign psc    = bus.dco_ctrl[4 +: PSC_W];
  assign per_in = bus.dco_cnt[N-1:0];
  assign hi_in  = bus.dco_duty[N-1:0];
  assign unused_bits = ^{bus.dco_ctrl, bus.dco_cnt, bus.dco_duty};

  // Tick once the prescaler has counted 2^psc_q enabled cycles.
  assign pre_mask = ~({PRE_W{1'b1}} << psc_q);
  assign tick     = (pre_q == pre_mask);
  assign term     = tick && (cnt_q == per_q);
  assign raw      = (cnt_q < hi_q);

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n)      state_q <= IDLE;
    else if (sys_clk_en) state_q <= state_d;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    clr     = 1'b0;
    up_d    = '0;
    val_d   = '0;
    unique case (state_q)
      IDLE: if (on) begin
        state_d       = RUN;
        load          = 1'b1;
        clr           = 1'b1;
        up_d[B_BUSY]  = 1'b1;
        val_d[B_BUSY] = 1'b1;
      end
      RUN: if (!on) begin
        // Abort wins over a coincident one-shot terminal tick.
        state_d      = IDLE;
        clr          = 1'b1;
        up_d[B_BUSY] = 1'b1;
      end else if (term && mode_q) begin
        state_d       = STOP;
        up_d[B_ON]    = 1'b1;
        up_d[B_BUSY]  = 1'b1;
        up_d[B_DONE]  = 1'b1;
        val_d[B_DONE] = 1'b1;
      end
      STOP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      cnt_q  <= '0;
      pre_q  <= '0;
      per_q  <= '0;
      hi_q   <= '0;
      psc_q  <= '0;
      mode_q <= 1'b0;
      out_q  <= 1'b0;
      up_q   <= '0;
      val_q  <= '0;
    end else if (sys_clk_en) begin
      up_q  <= up_d;
      val_q <= val_d;
      out_q <= (state_q == RUN) ? (raw ^ pol) : pol;
      if (load) begin
        per_q  <= per_in;
        hi_q   <= hi_in;
        psc_q  <= psc;
        mode_q <= mode;
      end
      if (clr) begin
        cnt_q <= '0;
        pre_q <= '0;
      end else if (state_q == RUN) begin
        pre_q <= tick ? '0 : pre_q + 1'b1;
        if (term) begin
          // Period boundary: the only point where SFR values reach the shadows.
          cnt_q <= '0;
          per_q <= per_in;
          hi_q  <= hi_in;
          psc_q <= psc;
        end else if (tick) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end else begin
      up_q  <= '0;
      val_q <= '0;
    end

  assign bus.hw_up_dco_ctrl  = up_q;
  assign bus.hw_val_dco_ctrl = val_q;
  assign bus.hw_up_dco_cnt   = '0;
  assign bus.hw_val_dco_cnt  = '0;
  assign bus.hw_up_dco_duty  = '0;
  assign bus.hw_val_dco_duty = '0;
  assign dco_clk_out         = out_q;
endmodule

// File: tb/tb_dco_nbit_v2.sv
// Randomized and directed checks of dco_nbit_v2 against an arithmetic waveform model.
module tb_dco_nbit_v2;
  logic sys_clk, sys_rst_n, sys_clk_en, dco_clk_out;
  int   n_cmp, n_bad;

  dco_nbit_v2_if #(.DATA_WIDTH(32)) bus ();

  dco_nbit_v2 #(.DATA_WIDTH(32), .N(20), .PSC_W(4)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .sys_clk_en (sys_clk_en),
    .bus        (bus),
    .dco_clk_out(dco_clk_out)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [31:0] mk_ctrl(input logic on, input logic mode,
                                          input logic pol, input int psc);
    logic [31:0] c;
    c = '0;
    c[0] = on;
    c[1] = mode;
    c[2] = pol;
    c[7:4] = 4'(psc);
    return c;
  endfunction

  // Level k enabled cycles after the first output level of a run.
  function automatic logic lvl(input int k, input int per, input int hi,
                               input int psc, input logic pol);
    int ph;
    ph = (k >> psc) % (per + 1);
    return (ph < hi) ^ pol;
  endfunction

  task automatic start(input int per, input int hi, input int psc,
                       input logic pol, input logic mode);
    bus.dco_cnt  = 32'(per);
    bus.dco_duty = 32'(hi);
    bus.dco_ctrl = mk_ctrl(1'b1, mode, pol, psc);
    step;
    chk("busy_up", bus.hw_up_dco_ctrl, 32'h100);
    chk("busy_val", bus.hw_val_dco_ctrl, 32'h100);
    chk("idle_lvl", dco_clk_out, pol);
    step;
    chk("strobe_end", bus.hw_up_dco_ctrl, 32'h0);
  endtask

  task automatic stop_chk(input logic pol);
    bus.dco_ctrl[0] = 1'b0;
    step;
    chk("stop_up", bus.hw_up_dco_ctrl, 32'h100);
    chk("stop_val", bus.hw_val_dco_ctrl, 32'h0);
    step;
    chk("stop_idle", dco_clk_out, pol);
    chk("stop_up0", bus.hw_up_dco_ctrl, 32'h0);
  endtask

  task automatic run_cont(input int per, input int hi, input int psc,
                          input logic pol, input int ncyc, input logic flip);
    start(per, hi, psc, pol, 1'b0);
    for (int k = 0; k < ncyc; k++) begin
      chk("cont_lvl", dco_clk_out, lvl(k, per, hi, psc, pol));
      if (flip && k == 3) bus.dco_ctrl[1] = 1'b1;
      step;
    end
    stop_chk(pol);
  endtask

  initial begin
    int per, hi, psc, len;
    logic pol;
    logic exp;
    n_cmp = 0;
    n_bad = 0;
    sys_rst_n = 1'b0;
    sys_clk_en = 1'b1;
    bus.dco_ctrl = '0;
    bus.dco_cnt = '0;
    bus.dco_duty = '0;
    step;
    step;
    chk("rst_out", dco_clk_out, 1'b0);
    chk("rst_up", bus.hw_up_dco_ctrl, 32'h0);
    chk("rst_val", bus.hw_val_dco_ctrl, 32'h0);
    chk("rst_cnt_up", bus.hw_up_dco_cnt | bus.hw_val_dco_cnt, 32'h0);
    chk("rst_duty_up", bus.hw_up_dco_duty | bus.hw_val_dco_duty, 32'h0);
    sys_rst_n = 1'b1;
    step;

    // Basic continuous wave, with a MODE write mid-run that must be ignored.
    run_cont(4, 2, 0, 1'b0, 15, 1'b1);

    // Corners for both polarities: HI=0, HI>PER, PER=0.
    for (int p = 0; p < 2; p++) begin
      run_cont(3, 0, 0, p[0], 10, 1'b0);
      run_cont(3, 7, 0, p[0], 10, 1'b0);
      run_cont(0, 1, 0, p[0], 6, 1'b0);
    end

    for (int t = 0; t < 6; t++) begin
      per = $urandom_range(0, 6);
      hi  = $urandom_range(0, 8);
      psc = $urandom_range(0, 2);
      pol = 1'($urandom_range(0, 1));
      run_cont(per, hi, psc, pol, (2 * (per + 1) << psc) + 3, 1'b0);
    end

    // Mid-period PER write only affects the following period.
    start(1, 1, 2, 1'b0, 1'b0);
    for (int k = 0; k < 28; k++) begin
      if (k < 8) exp = (k < 4);
      else       exp = (((k - 8) % 16) < 4);
      chk("reload_lvl", dco_clk_out, exp);
      chk("reload_cnt_up", bus.hw_up_dco_cnt | bus.hw_up_dco_duty, 32'h0);
      if (k == 2) bus.dco_cnt = 32'd3;
      step;
    end
    stop_chk(1'b0);

    // One-shot; the bench plays the SFR bank and applies the ON clear.
    for (int t = 0; t < 2; t++) begin
      psc = t;
      pol = 1'($urandom_range(0, 1));
      len = 3 << psc;
      start(2, 1, psc, pol, 1'b1);
      for (int k = 0; k < len; k++) begin
        chk("os_lvl", dco_clk_out, lvl(k, 2, 1, psc, pol));
        if (k == len - 1) begin
          chk("os_up", bus.hw_up_dco_ctrl, 32'h301);
          chk("os_val", bus.hw_val_dco_ctrl, 32'h200);
          bus.dco_ctrl[0] = 1'b0;
        end else begin
          chk("os_up0", bus.hw_up_dco_ctrl, 32'h0);
        end
        step;
      end
      for (int k = 0; k < 4; k++) begin
        chk("os_idle", dco_clk_out, pol);
        chk("os_quiet", bus.hw_up_dco_ctrl, 32'h0);
        step;
      end
    end

    // ON cleared exactly on the one-shot terminal tick: no DONE.
    start(2, 2, 0, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      chk("ab_lvl", dco_clk_out, lvl(k, 2, 2, 0, 1'b0));
      if (k == 1) bus.dco_ctrl[0] = 1'b0;
      step;
    end
    chk("ab_up", bus.hw_up_dco_ctrl, 32'h100);
    chk("ab_val", bus.hw_val_dco_ctrl, 32'h0);
    step;
    chk("ab_idle", dco_clk_out, 1'b0);
    chk("ab_quiet", bus.hw_up_dco_ctrl, 32'h0);

    // Enable dropped for 5 cycles stretches the waveform by 5 cycles.
    start(4, 2, 0, 1'b0, 1'b0);
    len = 0;
    for (int i = 0; i < 22; i++) begin
      chk("frz_lvl", dco_clk_out, lvl(len, 4, 2, 0, 1'b0));
      sys_clk_en = !(i >= 4 && i < 9);
      step;
      if (sys_clk_en) len++;
    end
    sys_clk_en = 1'b1;
    stop_chk(1'b0);

    // Asynchronous reset while the output is high.
    start(4, 2, 0, 1'b0, 1'b0);
    chk("prerst_hi", dco_clk_out, 1'b1);
    #1 sys_rst_n = 1'b0;
    #1;
    chk("arst_out", dco_clk_out, 1'b0);
    chk("arst_up", bus.hw_up_dco_ctrl, 32'h0);
    chk("arst_val", bus.hw_val_dco_ctrl, 32'h0);
    bus.dco_ctrl = '0;
    step;
    sys_rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step;
      chk("post_rst_idle", dco_clk_out, 1'b0);
      chk("post_rst_quiet", bus.hw_up_dco_ctrl, 32'h0);
    end
    run_cont(4, 2, 0, 1'b0, 10, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dco_nbit_v2.md
# dco_nbit_v2

Second-generation digital controlled oscillator: a prescaled N-bit period/duty waveform generator with continuous and one-shot modes, glitch-free shadowed reload of period and duty, and hardware status write-back to its control SFR. It sits on the peripheral bus next to the SFR block: SFR values are inputs, and hardware-update strobes/values go back to the SFR bank. The whole block runs on one clock domain, with no derived or gated clocks; `sys_clk_en` acts as a synchronous enable.

## Interface
- `DATA_WIDTH`, 32, SFR word width.
- `N`, 20, counter, period and duty width; N ≤ DATA_WIDTH.
- `PSC_W`, 4, prescaler exponent field width; divide ratio 2^PSC.

Ports:
- `sys_clk`  in  1  system clock; the block's only clock.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `sys_clk_en`  in  1  synchronous enable; 0 freezes all state.
- `dco_ctrl`  in  DATA_WIDTH  control SFR: [0] ON, [1] MODE (0 continuous, 1 one-shot), [2] POL, [4+PSC_W-1:4] PSC, [8] BUSY (hw), [9] DONE (hw, sticky, sw clears).
- `dco_cnt`  in  DATA_WIDTH  [N-1:0] PER: terminal count, period = PER+1 ticks.
- `dco_duty`  in  DATA_WIDTH  [N-1:0] HI: high-phase ticks.
- `hw_up_dco_ctrl`  out  DATA_WIDTH  per-bit hw write strobe to dco_ctrl.
- `hw_val_dco_ctrl`  out  DATA_WIDTH  per-bit hw write value.
- `hw_up_dco_cnt`, `hw_val_dco_cnt`, `hw_up_dco_duty`, `hw_val_dco_duty`  out  DATA_WIDTH  tied to 0.
- `dco_clk_out`  out  1  registered waveform.

## Operation
- Every register is reset by `sys_rst_n` = 0. After reset: counter = 0, prescaler = 0, shadows = 0, state IDLE, `dco_clk_out` = 0, all hw_up/hw_val outputs = 0.
- While `sys_clk_en` = 0, all state holds, including the output level; no hw_up strobes are issued.
- FSM states: IDLE, RUN, STOP.
  - IDLE → RUN when ON = 1: load shadow PER and HI, clear the counter and prescaler, issue BUSY=1.
  - RUN → IDLE when ON = 0: this takes effect on the next enabled cycle, even mid-period. The counter and prescaler are cleared, BUSY=0 is issued, and the output returns to idle.
  - RUN → STOP in one-shot mode, at the tick where counter == shadow PER.
  - STOP → IDLE after one cycle. In that cycle the block strobes ON=0, BUSY=0 and DONE=1 together.
- Prescaler:
  - A free-running PSC_W-wide-exponent counter produces a tick every 2^PSC enabled cycles.
  - PSC = 0 gives a tick every cycle.
  - A PSC change applies at the next period boundary, because PSC is shadowed with PER and HI.
- Counter: advances by 1 on each tick. On a tick where counter == shadow PER, it wraps to 0 and the shadows reload from the SFRs. SFR writes mid-period never alter the current period.
- Raw level = (counter < shadow HI).
  - HI = 0 gives a constant low.
  - HI > PER gives a constant high.
  - PER = 0 gives a constant level, selected by HI ≠ 0.
- Output polarity and idle level:
  - `dco_clk_out` = raw XOR POL, registered.
  - POL is applied live, not shadowed.
  - The idle level (IDLE/STOP) is POL.
- MODE is sampled at IDLE→RUN. Changes during RUN are ignored.
- If ON = 0 and the one-shot terminal condition fall in the same cycle, ON = 0 wins: no DONE is issued.
- Widths: the counter compare is unsigned, N bits. Only the low N bits of `dco_cnt` and `dco_duty` are used.

## Timing
- Start latency:
  - ON sampled as 1 at cycle t (enabled) → RUN from t+1.
  - First output level valid at t+2.
  - The BUSY strobe is visible on the hw outputs at t+1.
- Steady state:
  - Period = (PER+1)·2^PSC enabled cycles.
  - High time = min(HI, PER+1)·2^PSC.
- Stop latency: ON = 0 at t → idle output at t+2.
- One-shot: DONE, ON=0 and BUSY=0 strobes are asserted for exactly one cycle.
- hw_up bits are single-cycle pulses; hw_val is valid only while the matching hw_up bit is 1, and reads 0 otherwise.
- Asynchronous reset mid-period forces the output to 0 immediately. The block resumes only after a fresh ON is seen after reset deassertion.

## Test plan
- Continuous: PER=4, HI=2, PSC=0, POL=0 → 2 high / 3 low cycles repeating; BUSY strobe with value 1 one cycle after ON.
- Prescaler and reload: PSC=2, PER=1, HI=1; write PER=3 mid-period → current period stays 8 cycles, the next is 16 cycles with 4 high.
- One-shot: MODE=1, PER=2, HI=1 → one 3-cycle period, then single-cycle strobes ON=0, BUSY=0, DONE=1; output idles at POL.
- Corners: HI=0 → constant 0; HI=7 with PER=3 → constant 1; PER=0, HI=1 → constant 1; POL=1 inverts all of these and idles high.
- Freeze and abort: drop `sys_clk_en` for 5 cycles mid-period → waveform stretched by exactly 5 cycles. Clear ON on the terminal tick in one-shot mode → no DONE strobe.
- Reset mid-run: assert `sys_rst_n`=0 while output is high → output 0 immediately, all hw outputs 0; after release, output stays idle until ON is seen.
